ramp_capture_mc: RTL and testbench

Multi-channel, parametrised ramp-ADC capture block for the R2R ladder front end. Each channel latches the ramp code at the first qualifying comparator edge in a sweep. It substitutes full-scale when no crossing occurs, and optionally averages 2^AVG_LOG2 sweeps. Each channel presents its result on an independent valid/ready port. The block sits between the ramp generator / comparators and the downstream scaling and display logic.

---
 rtl/ramp_capture_pkg.sv | 11 +
 rtl/ramp_capture_channel.sv | 87 ++++++++
 rtl/ramp_capture_mc.sv | 58 +++++
 tb/tb_ramp_capture_mc.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramp_capture_pkg.sv
// ramp_capture_pkg: shared state encoding and helpers for the ramp capture block
package ramp_capture_pkg;
  typedef enum logic [1:0] {
    CAP_IDLE     = 2'd0,
    CAP_ARMED    = 2'd1,
    CAP_CAPTURED = 2'd2
  } cap_state_t;
  function automatic logic [63:0] full_scale(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction
endpackage

// File: rtl/ramp_capture_channel.sv
// ramp_capture_channel: one comparator channel: sync, edge detect, sweep FSM, averaging, output register
module ramp_capture_channel
  import ramp_capture_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int AVG_LOG2    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             edge_falling,
  input  logic             sweep_start,
  input  logic             sweep_end,
  input  logic [WIDTH-1:0] ramp_code,
  input  logic             compare,
  input  logic             result_ready,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] result_data,
  output logic             result_valid,
  output logic             no_cross,
  output logic             overrun
);
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [WIDTH-1:0] FS = WIDTH'(full_scale(WIDTH));
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic prev, cur, edge_q, armed, finish, publish, fin_nc, nc_acc;
  logic [WIDTH-1:0] cap, fin_cap;
  logic [AW-1:0] acc, sum;
  logic [CW-1:0] cnt;
  cap_state_t state, state_n;
  assign cur = sync[SYNC_STAGES-1];
  // edge qualification and sweep-finish arithmetic on the aligned samples
  always_comb begin
    edge_q  = edge_falling ? (prev & ~cur) : (~prev & cur);
    armed   = state == CAP_ARMED;
    finish  = sweep_end && state != CAP_IDLE;
    fin_cap = armed ? (edge_q ? ramp_code : FS) : cap;
    fin_nc  = armed && !edge_q;
    sum     = acc + AW'(fin_cap);
    publish = finish && cnt == LAST;
    state_n = sweep_start ? CAP_ARMED : finish ? CAP_IDLE : (armed && edge_q) ? CAP_CAPTURED : state;
  end
  // comparator synchroniser and previous-sample tracker, idle level follows edge polarity
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= {SYNC_STAGES{edge_falling}};
      prev <= edge_falling;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], compare};
      prev <= cur;
    end
  // sweep FSM; cap holds the first qualifying code of the sweep
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= CAP_IDLE;
      cap   <= '0;
    end else begin
      state <= state_n;
      cap   <= (armed && edge_q) ? ramp_code : cap;
    end
  // running average across sweeps, cleared on each publish
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc    <= '0;
      cnt    <= '0;
      nc_acc <= 1'b0;
    end else if (finish) begin
      acc    <= publish ? '0 : sum;
      cnt    <= publish ? '0 : cnt + CW'(1);
      nc_acc <= publish ? 1'b0 : nc_acc | fin_nc;
    end
  // result register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      result_data  <= '0;
      result_valid <= 1'b0;
      no_cross     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_data  <= publish ? sum[AW-1 -: WIDTH] : result_data;
      no_cross     <= publish ? (nc_acc | fin_nc) : no_cross;
      result_valid <= publish | (result_valid & ~result_ready);
      overrun      <= (overrun & ~clear_flags) | (publish & result_valid & ~result_ready);
    end
endmodule

// File: rtl/ramp_capture_mc.sv
// ramp_capture_mc: multi-channel ramp ADC capture with shared ramp alignment
module ramp_capture_mc
  import ramp_capture_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 2,
  parameter int AVG_LOG2    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sweep_start,
  input  logic                      sweep_end,
  input  logic [WIDTH-1:0]          ramp_code,
  input  logic [CHANNELS-1:0]       compare,
  input  logic                      edge_falling,
  output logic [CHANNELS*WIDTH-1:0] result_data,
  output logic [CHANNELS-1:0]       result_valid,
  input  logic [CHANNELS-1:0]       result_ready,
  output logic [CHANNELS-1:0]       no_cross,
  output logic [CHANNELS-1:0]       overrun,
  input  logic                      clear_flags
);
  logic [SYNC_STAGES*WIDTH-1:0] code_d;
  logic [SYNC_STAGES-1:0] start_d, end_d;
  // delay ramp and strobes to line up with the comparator synchronisers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      code_d  <= '0;
      start_d <= '0;
      end_d   <= '0;
    end else begin
      code_d  <= {code_d[(SYNC_STAGES-1)*WIDTH-1:0], ramp_code};
      start_d <= {start_d[SYNC_STAGES-2:0], sweep_start};
      end_d   <= {end_d[SYNC_STAGES-2:0], sweep_end};
    end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    ramp_capture_channel #(
      .WIDTH(WIDTH),
      .AVG_LOG2(AVG_LOG2),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .edge_falling(edge_falling),
      .sweep_start(start_d[SYNC_STAGES-1]),
      .sweep_end(end_d[SYNC_STAGES-1]),
      .ramp_code(code_d[SYNC_STAGES*WIDTH-1 -: WIDTH]),
      .compare(compare[c]),
      .result_ready(result_ready[c]),
      .clear_flags(clear_flags),
      .result_data(result_data[c*WIDTH +: WIDTH]),
      .result_valid(result_valid[c]),
      .no_cross(no_cross[c]),
      .overrun(overrun[c])
    );
  end
endmodule

// File: tb/tb_ramp_capture_mc.sv
// tb_ramp_capture_mc: scoreboard bench for ramp_capture_mc with and without averaging
module tb_ramp_capture_mc;
  localparam int S = 2;
  typedef struct {
    logic [7:0] d;
    logic       nc;
  } exp_t;
  logic clk, reset_n, sweep_start, sweep_end, edge_falling, clear_flags;
  logic [7:0] ramp_code;
  logic [1:0] compare;
  logic [31:0] rd_all;
  logic [3:0] rv_all, nc_all, ov_all, rr_all, rbit;
  int hold [4];
  int errors, checks;
  exp_t q [4][$];
  int acc [4], cnt [4];
  logic ncacc [4], ow [4], exp_ov [4];
  logic w [2][600];
  logic [7:0] codes [600];

  ramp_capture_mc #(.WIDTH(8), .CHANNELS(2), .AVG_LOG2(0), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .reset_n(reset_n), .sweep_start(sweep_start), .sweep_end(sweep_end),
    .ramp_code(ramp_code), .compare(compare), .edge_falling(edge_falling),
    .result_data(rd_all[15:0]), .result_valid(rv_all[1:0]), .result_ready(rr_all[1:0]),
    .no_cross(nc_all[1:0]), .overrun(ov_all[1:0]), .clear_flags(clear_flags));
  ramp_capture_mc #(.WIDTH(8), .CHANNELS(2), .AVG_LOG2(2), .SYNC_STAGES(S)) dut2 (
    .clk(clk), .reset_n(reset_n), .sweep_start(sweep_start), .sweep_end(sweep_end),
    .ramp_code(ramp_code), .compare(compare), .edge_falling(edge_falling),
    .result_data(rd_all[31:16]), .result_valid(rv_all[3:2]), .result_ready(rr_all[3:2]),
    .no_cross(nc_all[3:2]), .overrun(ov_all[3:2]), .clear_flags(clear_flags));

  for (genvar s = 0; s < 4; s++) begin : g_rdy
    assign rr_all[s] = hold[s] == 2 ? 1'b1 : hold[s] == 1 ? 1'b0 : rbit[s];
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    rbit = '1;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) rbit[s] = $urandom_range(3) != 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: a transfer happens at the next edge whenever valid and ready are both high
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n)
        for (int s = 0; s < 4; s++)
          if (rv_all[s] && rr_all[s]) begin
            checks++;
            if (q[s].size() == 0) begin
              errors++;
              $display("FAIL unexpected_result s%0d: got data %0h nc %0b, none expected", s, rd_all[s*8 +: 8], nc_all[s]);
            end else begin
              e = q[s].pop_front();
              if (rd_all[s*8 +: 8] !== e.d || nc_all[s] !== e.nc) begin
                errors++;
                $display("FAIL result s%0d: got data %0h nc %0b expected data %0h nc %0b",
                         s, rd_all[s*8 +: 8], nc_all[s], e.d, e.nc);
              end
            end
          end
    end
  end

  function automatic logic qual(input logic p, input logic c);
    return edge_falling ? (p & ~c) : (~p & c);
  endfunction

  // reference: first qualifying edge after the start cycle, full scale if none, then average
  task automatic model_sweep(input int len);
    exp_t e;
    int hit, cap, n, s;
    for (int c = 0; c < 2; c++) begin
      hit = -1;
      for (int i = 1; i < len; i++)
        if (hit < 0 && qual(w[c][i-1], w[c][i])) hit = i;
      cap = hit < 0 ? 255 : int'(codes[hit]);
      for (int k = 0; k < 2; k++) begin
        s = k * 2 + c;
        n = k == 0 ? 1 : 4;
        acc[s] += cap;
        cnt[s]++;
        ncacc[s] |= hit < 0;
        if (cnt[s] == n) begin
          e.d  = 8'(acc[s] / n);
          e.nc = ncacc[s];
          if (ow[s] && q[s].size() > 0) begin
            q[s][q[s].size()-1] = e;
            exp_ov[s] = 1'b1;
          end else q[s].push_back(e);
          acc[s] = 0;
          cnt[s] = 0;
          ncacc[s] = 1'b0;
        end
      end
    end
  endtask

  task automatic run_sweep(input int len);
    sweep_start = 0;
    sweep_end = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < len; i++) begin
      sweep_start = i == 0;
      sweep_end = i == len - 1;
      ramp_code = codes[i];
      compare = {w[1][i], w[0][i]};
      @(posedge clk);
      #1;
    end
    sweep_start = 0;
    sweep_end = 0;
    model_sweep(len);
  endtask

  task automatic prep_ramp(input int len);
    for (int i = 0; i < len; i++) codes[i] = 8'(i);
  endtask

  task automatic prep_step(input int c, input int len, input int at, input logic lvl0);
    for (int i = 0; i < len; i++) w[c][i] = i < at ? lvl0 : ~lvl0;
  endtask

  task automatic prep_rand(input int len);
    for (int i = 0; i < len; i++) codes[i] = 8'($urandom_range(255));
    for (int c = 0; c < 2; c++) begin
      w[c][0] = compare[c];
      for (int i = 1; i < len; i++) w[c][i] = w[c][i-1] ^ ($urandom_range(7) == 0);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still expected after %0d cycles",
               q[0].size() + q[1].size() + q[2].size() + q[3].size(), t);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      q[s].delete();
      acc[s] = 0;
      cnt[s] = 0;
      ncacc[s] = 1'b0;
      ow[s] = 1'b0;
      exp_ov[s] = 1'b0;
      hold[s] = 0;
    end
  endtask

  initial begin
    int ks [4] = '{10, 11, 12, 14};
    int len;
    errors = 0;
    checks = 0;
    reset_n = 0;
    edge_falling = 1;
    compare = 2'b11;
    ramp_code = 0;
    sweep_start = 0;
    sweep_end = 0;
    clear_flags = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rv_all), 0);
    chk("reset_data", rd_all, 0);
    chk("reset_nocross", 32'(nc_all), 0);
    chk("reset_overrun", 32'(ov_all), 0);
    reset_n = 1;

    prep_ramp(256);
    prep_step(0, 256, 'h5A, 1'b1);
    prep_step(1, 256, 999, 1'b1);
    run_sweep(256);
    repeat (S - 1) @(posedge clk);
    #1;
    chk("latency_early", 32'(rv_all[0]), 0);
    @(posedge clk);
    #1;
    chk("latency_valid", 32'(rv_all[0]), 1);

    prep_ramp('h50);
    for (int i = 0; i < 'h50; i++) w[0][i] = !((i >= 'h20 && i < 'h30) || i >= 'h40);
    prep_step(1, 'h50, 'h4F, 1'b1);
    run_sweep('h50);

    repeat (8) begin
      len = $urandom_range(12, 40);
      prep_rand(len);
      run_sweep(len);
    end

    drain();
    hold[0] = 1;
    ow[0] = 1'b1;
    prep_rand(30);
    run_sweep(30);
    repeat (S + 1) @(posedge clk);
    prep_rand(30);
    run_sweep(30);
    repeat (S) @(posedge clk);
    #1;
    chk("overrun_set", 32'(ov_all[0]), 1);
    chk("overrun_valid_held", 32'(rv_all[0]), 1);
    clear_flags = 1;
    @(posedge clk);
    #1;
    clear_flags = 0;
    exp_ov[0] = 1'b0;
    chk("overrun_clear", 32'(ov_all[0]), 0);
    ow[0] = 1'b0;
    prep_rand(30);
    run_sweep(30);
    repeat (S - 1) @(posedge clk);
    #1;
    hold[0] = 2;
    @(posedge clk);
    #1;
    chk("publish_xfer_valid", 32'(rv_all[0]), 1);
    chk("publish_xfer_no_overrun", 32'(ov_all[0]), 0);
    hold[0] = 0;

    drain();
    hold[1] = 1;
    prep_rand(20);
    run_sweep(20);
    repeat (S + 2) @(posedge clk);
    #1;
    sweep_start = 1;
    @(posedge clk);
    #1;
    sweep_start = 0;
    repeat (S + 2) @(posedge clk);
    #3;
    reset_n = 0;
    #1;
    chk("midreset_valid", 32'(rv_all), 0);
    chk("midreset_data", rd_all, 0);
    chk("midreset_nocross", 32'(nc_all), 0);
    chk("midreset_overrun", 32'(ov_all), 0);
    model_reset();
    edge_falling = 0;
    compare = 2'b00;
    @(posedge clk);
    #1;
    reset_n = 1;

    for (int k = 0; k < 4; k++) begin
      prep_ramp(40);
      prep_step(0, 40, ks[k], 1'b0);
      prep_step(1, 40, ks[k] + 5, 1'b0);
      run_sweep(40);
      if (k < 3) begin
        repeat (S + 1) @(posedge clk);
        #1;
        chk("avg_not_yet", 32'(rv_all[3:2]), 0);
      end
    end
    repeat (S) @(posedge clk);
    #1;
    chk("avg_valid", 32'(rv_all[3:2]), 3);

    repeat (8) begin
      len = $urandom_range(12, 40);
      prep_rand(len);
      run_sweep(len);
    end
    drain();
    for (int s = 0; s < 4; s++) chk($sformatf("overrun_final_s%0d", s), 32'(ov_all[s]), 32'(exp_ov[s]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
